std_fp_mult_seq_32_16_16: RTL and testbench
===========================================

// Module: std_fp_mult_seq_32_16_16
// PURPOSE
//  Sequential unsigned fixed-point multiplier, the inverse operator of the iterative fixed-point divider.
//  Same go/done latency-insensitive handshake, driven by a Calyx-style control FSM.
//  Radix-2 shift-add: one multiplier bit per cycle, WIDTH iterations, result truncated to Q(INT_WIDTH.FRAC_WIDTH).
// PARAMETERS
//  WIDTH       32  operand/result width in bits; must equal INT_WIDTH + FRAC_WIDTH
//  INT_WIDTH   16  integer bits of every operand and of the result
//  FRAC_WIDTH  16  fractional bits of every operand and of the result
// PORTS
//  clk    in   1      single clock; all state updates on posedge
//  reset  in   1      synchronous, active-high
//  go     in   1      request; held high by the caller until done
//  left   in   WIDTH  multiplicand, unsigned fixed point; sampled on the start cycle only
//  right  in   WIDTH  multiplier, unsigned fixed point; sampled on the start cycle only
//  out    out  WIDTH  product, truncated Q16.16; held stable between operations
//  done   out  1      one-cycle pulse; out is valid in the same cycle
// BEHAVIOUR
//  Reset: running=0, idx=0, product register=0, out=0, done=0. Reset wins over every other condition.
//  start = go && !running. On a start edge: latch mcand=left; P={(WIDTH+1)'b0, right}; idx=0; running=1.
//  Zero shortcut: at start, if left==0 or right==0, running stays 0, out<=0, done<=1.
//    done is then visible 1 cycle after go.
//  Iteration (running=1), each cycle:
//    P = ({P_hi + (P[0] ? mcand : 0), P_lo}) >> 1
//    P_hi is WIDTH+1 bits, so the carry is kept. idx increments.
//  finished = running && idx==WIDTH-1. On that edge:
//    out <= P_next[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH], done<=1, running<=0.
//  Latency: go sampled at cycle 0 -> done=1 and out valid in cycle WIDTH+1 (33). Not pipelined; one op in flight.
//  Arithmetic: full 2*WIDTH product, then truncate.
//    Low FRAC_WIDTH bits are dropped: round toward zero.
//    Bits above WIDTH+FRAC_WIDTH-1 are discarded: wrap, no saturation, no flag.
//  done is 0 in every other cycle. out changes only on a finished edge, a zero shortcut, or reset.
//  go low while running: the iteration still completes and done pulses. Callers must not rely on this.
//  go still high in the cycle after done: a new start occurs with the current left/right.
//    Calyx control drops go in that cycle.
//  Operand changes while running are ignored.
//  Reset mid-operation: abort immediately, out=0, no done pulse. The next go starts cleanly.
// STRUCTURE
//  Shared package std_fp_pkg:
//    localparam MULT_ITERS = WIDTH
//    function fp_trunc(product, FRAC_WIDTH) for the slice, shared with the sibling fp blocks.
//  idx width: $clog2(WIDTH). Control is a 2-state implicit FSM (IDLE / RUN) encoded by running.
//  One natural sub-module: std_fp_mult_step, combinational.
//    Takes P and mcand, returns next P (conditional add + shift right).
//    Reused by a future unrolled/pipelined variant.
// TESTING
//  1.5*2.25: left=0x0001_8000, right=0x0002_4000, hold go
//    -> done only in cycle 33, out=0x0003_6000.
//  Zero: left=0x0000_0000, right=0x1234_5678
//    -> done in cycle 1, out=0. Repeat with the zero on right; same response.
//  Truncation: left=0x0000_0001, right=0x0000_0001 -> out=0x0000_0000.
//    Then 0x0000_8000*0x0000_8000 (0.5*0.5) -> out=0x0000_4000.
//  Wrap and identity:
//    0x0100_0000*0x0100_0000 -> out=0x0000_0000.
//    0xFFFF_FFFF*0x0001_0000 -> out=0xFFFF_FFFF.
//  Reset mid-op: go at cycle 0, reset=1 at cycle 10
//    -> out=0 in cycle 11, no done pulse.
//    Then go with 2.0*3.0 (0x0002_0000, 0x0003_0000) -> out=0x0006_0000 after 33 cycles.
//  Back-to-back: drop go for one cycle after done, then reassert with new operands
//    -> second result correct, and out holds the first result until the second done.

Source files
------------

// File: rtl/std_fp_pkg.sv
// Shared constants, FSM state type and product-slicing helper for the fixed-point arithmetic blocks.
// Q16.16 unsigned format throughout; the multiplier keeps a (2*WIDTH+1)-bit partial-product register.
package std_fp_pkg;

  localparam int INT_WIDTH  = 16;
  localparam int FRAC_WIDTH = 16;
  localparam int WIDTH      = INT_WIDTH + FRAC_WIDTH;

  // One multiplier bit retired per cycle.
  localparam int MULT_ITERS = WIDTH;
  localparam int IDX_W      = $clog2(WIDTH);

  // Partial product: WIDTH+1 high bits keep the add carry, WIDTH low bits hold the shifting multiplier.
  localparam int P_W        = 2 * WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Drop frac_width fraction bits (round toward zero) and keep WIDTH bits (wrap on overflow).
  function automatic logic [WIDTH-1:0] fp_trunc(input logic [2*WIDTH-1:0] product,
                                                input int unsigned        frac_width);
    return WIDTH'(product >> frac_width);
  endfunction

endpackage

// File: rtl/std_fp_mult_seq_32_16_16_if.sv
// go/done request bus between a Calyx-style caller and the sequential fixed-point multiplier.
// The caller holds go and the operands; the multiplier answers with a one-cycle done pulse.
interface std_fp_mult_seq_32_16_16_if;
  import std_fp_pkg::*;

  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out;
  logic             done;

  modport master (
    output go,
    output left,
    output right,
    input  out,
    input  done
  );

  modport slave (
    input  go,
    input  left,
    input  right,
    output out,
    output done
  );

endinterface

// File: rtl/std_fp_mult_step.sv
// One radix-2 shift-add step: add mcand to the high half when the current multiplier bit is set, then shift right.
// Purely combinational so an unrolled variant can chain copies of it.
module std_fp_mult_step
  import std_fp_pkg::*;
(
  input  logic [P_W-1:0]   p_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [P_W-1:0]   p_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;

  always_comb begin
    addend = p_i[0] ? mcand_i : '0;
    // High half is always below 2^WIDTH before the add, so WIDTH+1 bits never overflow.
    sum    = p_i[P_W-1:WIDTH] + {1'b0, addend};
    p_o    = {sum, p_i[WIDTH-1:0]} >> 1;
  end

endmodule

// File: rtl/std_fp_mult_seq_32_16_16.sv
// Sequential unsigned Q16.16 multiplier, one multiplier bit per cycle; done pulses 33 cycles after go (1 if an operand is 0).
// Single operation in flight; operands are sampled only on the start cycle and result holds until the next one.
module std_fp_mult_seq_32_16_16
  import std_fp_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  std_fp_mult_seq_32_16_16_if.slave   bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [P_W-1:0]   p_q,     p_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             done_q,  done_d;

  logic [P_W-1:0]   p_next;
  logic             carry_unused;

  std_fp_mult_step u_step (
    .p_i     (p_q),
    .mcand_i (mcand_q),
    .p_o     (p_next)
  );

  // After the final shift the full product sits in the low 2*WIDTH bits; the top bit is always 0.
  assign carry_unused = p_next[P_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mcand_q <= '0;
      p_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    out_d   = out_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          if ((bus.left == '0) || (bus.right == '0)) begin
            // Zero operand: answer next cycle without iterating.
            out_d  = '0;
            done_d = 1'b1;
          end else begin
            mcand_d = bus.left;
            p_d     = {{(WIDTH + 1){1'b0}}, bus.right};
            idx_d   = '0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        p_d   = p_next;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(MULT_ITERS - 1)) begin
          out_d   = fp_trunc(p_next[2*WIDTH-1:0], FRAC_WIDTH);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_std_fp_mult_seq_32_16_16.sv
// Directed and random operations against an arithmetic reference product, checking latency, result and hold behaviour.
module tb_std_fp_mult_seq_32_16_16;

  logic clk = 1'b0;
  logic reset;

  std_fp_mult_seq_32_16_16_if bus ();

  std_fp_mult_seq_32_16_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] prev_out;

  // Full 64-bit product scaled back by 2^16 and reduced modulo 2^32.
  function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return 32'((full / 64'd65536) % 64'h1_0000_0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: the remainder of this cycle is cycle 0, go is sampled at its closing posedge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat_exp;
    int lat;
    lat_exp = (a == 32'd0 || b == 32'd0) ? 1 : 33;
    lat     = -1;
    bus.go    = 1'b1;
    bus.left  = a;
    bus.right = b;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      check({tag, " hold"}, 64'(bus.out), 64'(prev_out));
      bus.left  = $urandom;
      bus.right = $urandom;
    end
    bus.go = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(lat_exp));
    check({tag, " out"}, 64'(bus.out), 64'(exp));
    @(negedge clk);
    check({tag, " pulse"}, 64'(bus.done), 64'(0));
    check({tag, " keep"}, 64'(bus.out), 64'(exp));
    prev_out = exp;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          done_seen;

    reset     = 1'b1;
    bus.go    = 1'b0;
    bus.left  = '0;
    bus.right = '0;
    repeat (3) @(negedge clk);
    check("reset out", 64'(bus.out), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle done", 64'(bus.done), 64'(0));
    prev_out = 32'd0;

    run_op("1.5x2.25", 32'h0001_8000, 32'h0002_4000, 32'h0003_6000);
    run_op("zero left", 32'h0000_0000, 32'h1234_5678, 32'h0000_0000);
    run_op("zero right", 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
    run_op("ulp trunc", 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
    run_op("half sq", 32'h0000_8000, 32'h0000_8000, 32'h0000_4000);
    run_op("wrap", 32'h0100_0000, 32'h0100_0000, 32'h0000_0000);
    run_op("identity", 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF);
    run_op("nonzero again", 32'h0003_0000, 32'h0000_C000, 32'h0002_4000);

    // Abort mid-operation: reset sampled at the end of cycle 10.
    bus.go    = 1'b1;
    bus.left  = 32'h0005_0000;
    bus.right = 32'h0007_0000;
    done_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    reset  = 1'b1;
    bus.go = 1'b0;
    @(negedge clk);
    check("abort out", 64'(bus.out), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'(0));
    prev_out = 32'd0;

    run_op("2x3 after abort", 32'h0002_0000, 32'h0003_0000, 32'h0006_0000);

    for (int k = 0; k < 16; k++) begin
      a = $urandom;
      b = $urandom;
      a = a >> $urandom_range(0, 24);
      b = b >> $urandom_range(0, 24);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      run_op($sformatf("rand%0d", k), a, b, ref_mult(a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
